// File: rtl/riscv_run_monitor_if.sv
// riscv_run_monitor_if
//   Bundles the signals exchanged between the run monitor and the
//   core/bench around it.
//   master : drives restart and the core observation signals
//            (pc, mem_we, mem_addr, mem_wdata); receives results.
//   slave  : the run monitor itself; observes the core, drives
//            core_rst_n, done, status, fail_code, cycle_count.
//   Protocol: there is no valid/ready pair here. restart is a one-cycle
//   pulse that is only acted on while the monitor is in DONE; all other
//   inputs are sampled every RUN cycle on the rising clock edge.
interface riscv_run_monitor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  restart;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  core_rst_n;
    logic                  done;
    logic [2:0]            status;
    logic [DATA_WIDTH-1:0] fail_code;
    logic [CNT_WIDTH-1:0]  cycle_count;

    modport master (
        output restart, pc, mem_we, mem_addr, mem_wdata,
        input  core_rst_n, done, status, fail_code, cycle_count
    );

    modport slave (
        input  restart, pc, mem_we, mem_addr, mem_wdata,
        output core_rst_n, done, status, fail_code, cycle_count
    );
endinterface

// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor
//   Run controller for the single-cycle RISC-V core. Holds the core in
//   reset for RST_CYCLES cycles, then counts RUN cycles while watching the
//   data-memory write port for a store to TOHOST_ADDR. A run also ends on
//   cycle-budget timeout or when the PC stays unchanged for HANG_CYCLES
//   consecutive cycles. On termination the core is put back into reset and
//   a status code is held until restart.
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : slave side of riscv_run_monitor_if (restart, pc, mem_*
//                in; core_rst_n, done, status, fail_code, cycle_count out)
//   state_dbg  : current FSM state (0 HOLD, 1 RUN, 2 DONE)
module riscv_run_monitor #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    CNT_WIDTH   = 32,
    parameter int                    RST_CYCLES  = 2,
    parameter int                    MAX_CYCLES  = 1024,
    parameter int                    HANG_CYCLES = 16,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h00000FF0
) (
    input  logic               clk,
    input  logic               rst,
    riscv_run_monitor_if.slave bus,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] ST_RUNNING = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_HANG    = 3'd4;

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
    // With HANG_CYCLES == 0 this wraps to all-ones, but hang detection is
    // disabled in that case so the value is never used.
    localparam logic [CNT_WIDTH-1:0] HANG_LAST = CNT_WIDTH'(HANG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    logic [1:0]            state_q,      state_n;
    logic [HOLD_W-1:0]     hold_cnt_q,   hold_cnt_n;
    logic                  core_rst_n_q, core_rst_n_n;
    logic                  done_q,       done_n;
    logic [2:0]            status_q,     status_n;
    logic [DATA_WIDTH-1:0] fail_code_q,  fail_code_n;
    logic [CNT_WIDTH-1:0]  cycle_cnt_q,  cycle_cnt_n;
    logic [CNT_WIDTH-1:0]  hang_cnt_q,   hang_cnt_n;
    logic [ADDR_WIDTH-1:0] pc_q,         pc_n;
    // pc_q holds nothing meaningful until one RUN cycle has registered it.
    logic                  pc_valid_q,   pc_valid_n;

    logic                  tohost_hit;
    logic                  timeout_hit;
    logic                  pc_same;
    logic                  hang_hit;
    logic                  terminate;
    logic [CNT_WIDTH-1:0]  cycle_cnt_inc;
    logic [CNT_WIDTH-1:0]  hang_cnt_inc;

    always_comb begin
        tohost_hit    = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
        timeout_hit   = (cycle_cnt_q == CNT_LAST);
        pc_same       = pc_valid_q && (bus.pc == pc_q);
        hang_hit      = (HANG_CYCLES != 0) && (hang_cnt_q == HANG_LAST) && pc_same;
        terminate     = tohost_hit || timeout_hit || hang_hit;
        // Both counters saturate rather than wrap.
        cycle_cnt_inc = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        hang_cnt_inc  = (hang_cnt_q == CNT_MAX) ? hang_cnt_q : hang_cnt_q + 1'b1;
    end

    always_comb begin
        state_n      = state_q;
        hold_cnt_n   = hold_cnt_q;
        core_rst_n_n = core_rst_n_q;
        done_n       = done_q;
        status_n     = status_q;
        fail_code_n  = fail_code_q;
        cycle_cnt_n  = cycle_cnt_q;
        hang_cnt_n   = hang_cnt_q;
        pc_n         = pc_q;
        pc_valid_n   = pc_valid_q;

        case (state_q)
            S_HOLD: begin
                core_rst_n_n = 1'b0;
                pc_valid_n   = 1'b0;
                hang_cnt_n   = '0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_n      = S_RUN;
                    core_rst_n_n = 1'b1;
                    hold_cnt_n   = '0;
                end else begin
                    hold_cnt_n = hold_cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                cycle_cnt_n = cycle_cnt_inc;
                pc_n        = bus.pc;
                pc_valid_n  = 1'b1;
                hang_cnt_n  = pc_same ? hang_cnt_inc : '0;

                // Priority: tohost store, then timeout, then hang.
                if (tohost_hit) begin
                    if (bus.mem_wdata == DATA_WIDTH'(1)) begin
                        status_n = ST_PASS;
                    end else begin
                        status_n    = ST_FAIL;
                        fail_code_n = bus.mem_wdata >> 1;
                    end
                end else if (timeout_hit) begin
                    status_n = ST_TIMEOUT;
                end else if (hang_hit) begin
                    status_n = ST_HANG;
                end

                if (terminate) begin
                    state_n      = S_DONE;
                    done_n       = 1'b1;
                    core_rst_n_n = 1'b0;
                end
            end

            S_DONE: begin
                if (bus.restart) begin
                    state_n     = S_HOLD;
                    done_n      = 1'b0;
                    status_n    = ST_RUNNING;
                    fail_code_n = '0;
                    cycle_cnt_n = '0;
                    hang_cnt_n  = '0;
                    hold_cnt_n  = '0;
                    pc_valid_n  = 1'b0;
                end
            end

            default: begin
                state_n      = S_HOLD;
                core_rst_n_n = 1'b0;
                hold_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= ST_RUNNING;
            fail_code_q  <= '0;
            cycle_cnt_q  <= '0;
            hang_cnt_q   <= '0;
            pc_q         <= '0;
            pc_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_n;
            hold_cnt_q   <= hold_cnt_n;
            core_rst_n_q <= core_rst_n_n;
            done_q       <= done_n;
            status_q     <= status_n;
            fail_code_q  <= fail_code_n;
            cycle_cnt_q  <= cycle_cnt_n;
            hang_cnt_q   <= hang_cnt_n;
            pc_q         <= pc_n;
            pc_valid_q   <= pc_valid_n;
        end
    end

    assign bus.core_rst_n  = core_rst_n_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;
    assign bus.fail_code   = fail_code_q;
    assign bus.cycle_count = cycle_cnt_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
module tb_riscv_run_monitor;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [31:0] TOHOST = 32'h00000FF0;

    logic        clk;
    logic        rst;
    logic        restart;
    logic [31:0] pc;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  state_a;
    logic [1:0]  state_b;

    int n_vec;
    int n_err;

    riscv_run_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) bus_a ();
    riscv_run_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) bus_b ();

    assign bus_a.restart   = restart;
    assign bus_a.pc        = pc;
    assign bus_a.mem_we    = mem_we;
    assign bus_a.mem_addr  = mem_addr;
    assign bus_a.mem_wdata = mem_wdata;
    assign bus_b.restart   = restart;
    assign bus_b.pc        = pc;
    assign bus_b.mem_we    = mem_we;
    assign bus_b.mem_addr  = mem_addr;
    assign bus_b.mem_wdata = mem_wdata;

    // Main DUT: hang detection enabled.
    riscv_run_monitor #(
        .RST_CYCLES(2), .MAX_CYCLES(20), .HANG_CYCLES(8), .TOHOST_ADDR(TOHOST)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .state_dbg(state_a)
    );

    // Same stimulus with hang detection disabled.
    riscv_run_monitor #(
        .RST_CYCLES(2), .MAX_CYCLES(20), .HANG_CYCLES(0), .TOHOST_ADDR(TOHOST)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .state_dbg(state_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            pc = pc + 32'd4;
            step();
        end
    endtask

    task automatic store_cycle(input logic [31:0] addr, input logic [31:0] data);
        pc        = pc + 32'd4;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        step();
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic reset_to_run();
        rst     = 1'b0;
        restart = 1'b0;
        mem_we  = 1'b0;
        pc      = '0;
        #2;
        rst = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        n_vec++; if (bus_a.core_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_core_rst_n: got %0h want 0", bus_a.core_rst_n); end
        n_vec++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0h want 0", bus_a.done); end
        n_vec++; if (bus_a.status !== 3'd0) begin n_err++; $display("FAIL rst_status: got %0h want 0", bus_a.status); end
        n_vec++; if (bus_a.fail_code !== 32'd0) begin n_err++; $display("FAIL rst_fail_code: got %0h want 0", bus_a.fail_code); end
        n_vec++; if (bus_a.cycle_count !== 32'd0) begin n_err++; $display("FAIL rst_cycle_count: got %0h want 0", bus_a.cycle_count); end
        n_vec++; if (state_a !== S_HOLD) begin n_err++; $display("FAIL rst_state: got %0h want %0h", state_a, S_HOLD); end
        step();
        rst = 1'b1;
        step();
        n_vec++; if (bus_a.core_rst_n !== 1'b0) begin n_err++; $display("FAIL hold_edge1: got %0h want 0", bus_a.core_rst_n); end
        n_vec++; if (state_a !== S_HOLD) begin n_err++; $display("FAIL hold_state1: got %0h want %0h", state_a, S_HOLD); end
        step();
        n_vec++; if (bus_a.core_rst_n !== 1'b1) begin n_err++; $display("FAIL hold_edge2: got %0h want 1", bus_a.core_rst_n); end
        n_vec++; if (state_a !== S_RUN) begin n_err++; $display("FAIL run_state: got %0h want %0h", state_a, S_RUN); end
        n_vec++; if (bus_a.done !== 1'b0 || bus_a.status !== 3'd0) begin n_err++; $display("FAIL run_entry_status: got done=%0h status=%0h want 0/0", bus_a.done, bus_a.status); end
    endtask

    task automatic test_pass();
        reset_to_run();
        run_cycles(9);
        n_vec++; if (bus_a.cycle_count !== 32'd9 || bus_a.done !== 1'b0) begin n_err++; $display("FAIL pass_pre: got count=%0d done=%0h want 9/0", bus_a.cycle_count, bus_a.done); end
        store_cycle(TOHOST, 32'd1);
        n_vec++; if (bus_a.done !== 1'b1) begin n_err++; $display("FAIL pass_done: got %0h want 1", bus_a.done); end
        n_vec++; if (bus_a.status !== 3'd1) begin n_err++; $display("FAIL pass_status: got %0h want 1", bus_a.status); end
        n_vec++; if (bus_a.cycle_count !== 32'd10) begin n_err++; $display("FAIL pass_count: got %0d want 10", bus_a.cycle_count); end
        n_vec++; if (bus_a.core_rst_n !== 1'b0) begin n_err++; $display("FAIL pass_core_rst_n: got %0h want 0", bus_a.core_rst_n); end
        n_vec++; if (state_a !== S_DONE) begin n_err++; $display("FAIL pass_state: got %0h want %0h", state_a, S_DONE); end
        // Activity while DONE must not disturb the held result.
        store_cycle(TOHOST, 32'd5);
        run_cycles(3);
        n_vec++; if (bus_a.status !== 3'd1 || bus_a.cycle_count !== 32'd10 || bus_a.fail_code !== 32'd0) begin n_err++; $display("FAIL done_hold: got status=%0h count=%0d fail=%0h want 1/10/0", bus_a.status, bus_a.cycle_count, bus_a.fail_code); end
    endtask

    task automatic test_fail_restart();
        reset_to_run();
        run_cycles(3);
        restart = 1'b1;
        run_cycles(1);
        restart = 1'b0;
        n_vec++; if (state_a !== S_RUN || bus_a.cycle_count !== 32'd4) begin n_err++; $display("FAIL restart_in_run: got state=%0h count=%0d want %0h/4", state_a, bus_a.cycle_count, S_RUN); end
        store_cycle(TOHOST + 32'd4, 32'd1);
        n_vec++; if (bus_a.done !== 1'b0 || bus_a.cycle_count !== 32'd5) begin n_err++; $display("FAIL other_addr: got done=%0h count=%0d want 0/5", bus_a.done, bus_a.cycle_count); end
        store_cycle(TOHOST, 32'h7);
        n_vec++; if (bus_a.status !== 3'd2) begin n_err++; $display("FAIL fail_status: got %0h want 2", bus_a.status); end
        n_vec++; if (bus_a.fail_code !== 32'd3) begin n_err++; $display("FAIL fail_code: got %0h want 3", bus_a.fail_code); end
        n_vec++; if (bus_a.cycle_count !== 32'd6 || bus_a.done !== 1'b1) begin n_err++; $display("FAIL fail_count: got count=%0d done=%0h want 6/1", bus_a.cycle_count, bus_a.done); end
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_vec++; if (bus_a.done !== 1'b0 || bus_a.status !== 3'd0 || bus_a.fail_code !== 32'd0 || bus_a.cycle_count !== 32'd0) begin n_err++; $display("FAIL restart_clear: got done=%0h status=%0h fail=%0h count=%0d want all 0", bus_a.done, bus_a.status, bus_a.fail_code, bus_a.cycle_count); end
        n_vec++; if (state_a !== S_HOLD || bus_a.core_rst_n !== 1'b0) begin n_err++; $display("FAIL restart_hold: got state=%0h core_rst_n=%0h want %0h/0", state_a, bus_a.core_rst_n, S_HOLD); end
        step();
        n_vec++; if (bus_a.core_rst_n !== 1'b0) begin n_err++; $display("FAIL restart_hold2: got %0h want 0", bus_a.core_rst_n); end
        step();
        n_vec++; if (bus_a.core_rst_n !== 1'b1 || state_a !== S_RUN) begin n_err++; $display("FAIL restart_run: got core_rst_n=%0h state=%0h want 1/%0h", bus_a.core_rst_n, state_a, S_RUN); end
    endtask

    task automatic test_timeout();
        reset_to_run();
        run_cycles(19);
        n_vec++; if (bus_a.done !== 1'b0 || bus_a.cycle_count !== 32'd19) begin n_err++; $display("FAIL timeout_pre: got done=%0h count=%0d want 0/19", bus_a.done, bus_a.cycle_count); end
        run_cycles(1);
        n_vec++; if (bus_a.status !== 3'd3 || bus_a.done !== 1'b1) begin n_err++; $display("FAIL timeout_status: got status=%0h done=%0h want 3/1", bus_a.status, bus_a.done); end
        n_vec++; if (bus_a.cycle_count !== 32'd20) begin n_err++; $display("FAIL timeout_count: got %0d want 20", bus_a.cycle_count); end
        reset_to_run();
        run_cycles(19);
        store_cycle(TOHOST, 32'd1);
        n_vec++; if (bus_a.status !== 3'd1 || bus_a.cycle_count !== 32'd20) begin n_err++; $display("FAIL tohost_over_timeout: got status=%0h count=%0d want 1/20", bus_a.status, bus_a.cycle_count); end
    endtask

    task automatic test_hang();
        reset_to_run();
        run_cycles(4);
        pc = 32'h40;
        for (int i = 0; i < 8; i++) step();
        n_vec++; if (bus_a.done !== 1'b0 || bus_a.cycle_count !== 32'd12) begin n_err++; $display("FAIL hang_pre: got done=%0h count=%0d want 0/12", bus_a.done, bus_a.cycle_count); end
        step();
        n_vec++; if (bus_a.status !== 3'd4 || bus_a.done !== 1'b1) begin n_err++; $display("FAIL hang_status: got status=%0h done=%0h want 4/1", bus_a.status, bus_a.done); end
        n_vec++; if (bus_a.cycle_count !== 32'd13) begin n_err++; $display("FAIL hang_count: got %0d want 13", bus_a.cycle_count); end
        n_vec++; if (bus_b.done !== 1'b0 || bus_b.cycle_count !== 32'd13) begin n_err++; $display("FAIL nohang_running: got done=%0h count=%0d want 0/13", bus_b.done, bus_b.cycle_count); end
        for (int i = 0; i < 7; i++) step();
        n_vec++; if (bus_b.status !== 3'd3 || bus_b.cycle_count !== 32'd20 || bus_b.done !== 1'b1) begin n_err++; $display("FAIL nohang_timeout: got status=%0h count=%0d done=%0h want 3/20/1", bus_b.status, bus_b.cycle_count, bus_b.done); end
        n_vec++; if (bus_a.cycle_count !== 32'd13 || state_a !== S_DONE) begin n_err++; $display("FAIL hang_frozen: got count=%0d state=%0h want 13/%0h", bus_a.cycle_count, state_a, S_DONE); end
    endtask

    task automatic test_midrun_reset();
        reset_to_run();
        run_cycles(7);
        n_vec++; if (bus_a.cycle_count !== 32'd7) begin n_err++; $display("FAIL mid_pre: got %0d want 7", bus_a.cycle_count); end
        rst = 1'b0;
        #2;
        n_vec++; if (bus_a.core_rst_n !== 1'b0 || bus_a.cycle_count !== 32'd0 || state_a !== S_HOLD) begin n_err++; $display("FAIL mid_async: got core_rst_n=%0h count=%0d state=%0h want 0/0/%0h", bus_a.core_rst_n, bus_a.cycle_count, state_a, S_HOLD); end
        n_vec++; if (bus_a.done !== 1'b0 || bus_a.status !== 3'd0 || bus_a.fail_code !== 32'd0) begin n_err++; $display("FAIL mid_async_status: got done=%0h status=%0h fail=%0h want 0/0/0", bus_a.done, bus_a.status, bus_a.fail_code); end
        #2;
        rst = 1'b1;
        pc  = '0;
        step();
        n_vec++; if (bus_a.core_rst_n !== 1'b0) begin n_err++; $display("FAIL mid_hold1: got %0h want 0", bus_a.core_rst_n); end
        step();
        n_vec++; if (bus_a.core_rst_n !== 1'b1 || bus_a.cycle_count !== 32'd0) begin n_err++; $display("FAIL mid_hold2: got core_rst_n=%0h count=%0d want 1/0", bus_a.core_rst_n, bus_a.cycle_count); end
        run_cycles(2);
        store_cycle(TOHOST, 32'd1);
        n_vec++; if (bus_a.status !== 3'd1 || bus_a.cycle_count !== 32'd3) begin n_err++; $display("FAIL mid_rerun: got status=%0h count=%0d want 1/3", bus_a.status, bus_a.cycle_count); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        restart   = 1'b0;
        pc        = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        #1;
        test_reset();
        test_pass();
        test_fail_restart();
        test_timeout();
        test_hang();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
